// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package demux_pkg;

  localparam int NUM_CH  = 4;
  localparam int DEMUX_W = 2;

  // Channel index encodings of the {s1,s0} select.
  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready holding register for a single output channel.
// Latency: 1 cycle from fill to out_valid.
// Backpressure: can_fill = !out_valid | out_ready, so a drain and a refill may share an edge.
module demux_slot #(
  parameter int WIDTH = demux_pkg::DEMUX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             can_fill
);

  // Slot has room when empty or when its current word leaves this cycle.
  always_comb begin
    can_fill = !out_valid || out_ready;
  end

  // Fill wins over drain so back-to-back words keep the slot full.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fill) begin
      out_valid <= 1'b1;
      out_data  <= fill_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_to_4_stream.sv
// Registered 1-to-4 stream demux: routes each accepted word to the slot chosen by {s1,s0}.
// Latency: 1 cycle from accept to outN_valid; 1 word/cycle per channel.
// Backpressure: in_ready follows the selected slot only; optional DEMUX_BCAST_EN adds bcast (needs all slots free).
module demux_1_to_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             s1,
  input  logic             s0,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef DEMUX_BCAST_EN
  input  logic             bcast,
`endif
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready
);

  logic [1:0]        ch;
  logic [NUM_CH-1:0] can_fill;
  logic [NUM_CH-1:0] fill;
  logic [NUM_CH-1:0] ready_vec;
  logic [NUM_CH-1:0] valid_vec;
  logic [WIDTH-1:0]  data_vec [NUM_CH];
  logic              fire;
  logic              bcast_on;

  assign ch        = {s1, s0};
  assign ready_vec = {out3_ready, out2_ready, out1_ready, out0_ready};

`ifdef DEMUX_BCAST_EN
  assign bcast_on = bcast;
`else
  assign bcast_on = 1'b0;
`endif

  // Readiness and per-slot fill strobes; a broadcast lands in every slot or none.
  always_comb begin
    fill = '0;
    if (bcast_on) begin
      in_ready = &can_fill;
    end else begin
      in_ready = can_fill[ch];
    end
    fire = in_valid && in_ready;
    if (fire) begin
      if (bcast_on) begin
        fill = '1;
      end else begin
        fill[ch] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .fill      (fill[i]),
      .fill_data (in_data),
      .out_data  (data_vec[i]),
      .out_valid (valid_vec[i]),
      .out_ready (ready_vec[i]),
      .can_fill  (can_fill[i])
    );
  end

  assign out0_data  = data_vec[CH0];
  assign out1_data  = data_vec[CH1];
  assign out2_data  = data_vec[CH2];
  assign out3_data  = data_vec[CH3];
  assign out0_valid = valid_vec[CH0];
  assign out1_valid = valid_vec[CH1];
  assign out2_valid = valid_vec[CH2];
  assign out3_valid = valid_vec[CH3];

endmodule

// File: tb/tb_demux_1_to_4_stream.sv
// Scoreboard bench for demux_1_to_4_stream; bcast scenario included when DEMUX_BCAST_EN is defined.
// Latency: expects words visible one cycle after accept.
// Backpressure: source holds word and select stable while in_ready=0.
module tb_demux_1_to_4_stream;
  import demux_pkg::*;

  localparam int W = DEMUX_W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         s1, s0, in_valid, in_ready;
  logic         bcast;
  logic [W-1:0] od [4];
  logic [3:0]   ov;
  logic [3:0]   ordy;

  logic [W-1:0] q [4][$];
  int           n_chk = 0;
  int           n_err = 0;
  bit           chk_en = 0;
  bit           last_fire = 0;

  always #5 clk = ~clk;

  demux_1_to_4_stream #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .s1         (s1),
    .s0         (s0),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
`ifdef DEMUX_BCAST_EN
    .bcast      (bcast),
`endif
    .out0_data  (od[0]),
    .out1_data  (od[1]),
    .out2_data  (od[2]),
    .out3_data  (od[3]),
    .out0_valid (ov[0]),
    .out1_valid (ov[1]),
    .out2_valid (ov[2]),
    .out3_valid (ov[3]),
    .out0_ready (ordy[0]),
    .out1_ready (ordy[1]),
    .out2_ready (ordy[2]),
    .out3_ready (ordy[3])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit vld, input int ch, input int dat);
    in_valid = vld;
    {s1, s0} = 2'(ch);
    in_data  = W'(dat);
  endtask

  // One clock: check outputs against the model at negedge, then advance the model.
  task automatic step();
    bit exp_rdy;
    int ch;
    bit bc;
    @(negedge clk);
    ch = int'({s1, s0});
    bc = 1'b0;
`ifdef DEMUX_BCAST_EN
    bc = bcast;
`endif
    if (bc) begin
      exp_rdy = 1'b1;
      for (int i = 0; i < 4; i++)
        if (q[i].size() != 0 && !ordy[i]) exp_rdy = 1'b0;
    end else begin
      exp_rdy = (q[ch].size() == 0) || ordy[ch];
    end
    if (chk_en && !rst) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("valid%0d", i), int'(ov[i]), int'(q[i].size() != 0));
        if (q[i].size() != 0) check($sformatf("data%0d", i), int'(od[i]), int'(q[i][0]));
      end
      check("in_ready", int'(in_ready), int'(exp_rdy));
    end
    last_fire = in_valid && exp_rdy && !rst;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      chk_en = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++)
        if (q[i].size() != 0 && ordy[i]) void'(q[i].pop_front());
      if (last_fire) begin
        if (bc) begin
          for (int i = 0; i < 4; i++) q[i].push_back(in_data);
        end else begin
          q[ch].push_back(in_data);
        end
      end
    end
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_valid%0d", tag, i), int'(ov[i]), 0);
      check($sformatf("%s_data%0d", tag, i), int'(od[i]), 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    bcast = 1'b0;
    ordy  = 4'hF;
    drive(1'b1, 0, 3);

    // Reset held two cycles with a valid word present: nothing is captured.
    step();
    check_reset_state("rst_a");
    step();
    check_reset_state("rst_b");
    rst = 1'b0;
    drive(1'b0, 0, 0);
    step();

    // Routing sweep: word k to channel k on consecutive cycles.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k, k);
      step();
      check($sformatf("sweep_fire%0d", k), int'(last_fire), 1);
    end
    drive(1'b0, 0, 0);
    step();
    step();

    // Backpressure on channel 2.
    ordy = 4'b1011;
    drive(1'b1, 2, 2);
    step();
    drive(1'b1, 2, 1);
    step();
    check("bp_stall", int'(last_fire), 0);
    step();
    check("bp_hold", int'(od[2]), 2);
    ordy = 4'hF;
    step();
    check("bp_release", int'(last_fire), 1);
    drive(1'b0, 0, 0);
    check("bp_new", int'(od[2]), 1);
    check("bp_valid", int'(ov[2]), 1);
    step();
    step();

    // Independence: ch1 stuck full while ch3 streams every cycle.
    ordy = 4'b1101;
    drive(1'b1, 1, 2);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 3, (k % 2 == 0) ? 3 : k);
      step();
      check($sformatf("ind_fire%0d", k), int'(last_fire), 1);
    end
    drive(1'b0, 0, 0);
    step();
    check("ind_ch1", int'(od[1]), 2);

    // Reset mid-operation with ch0, ch1 and ch3 full.
    ordy = 4'h0;
    drive(1'b1, 0, 1);
    step();
    drive(1'b1, 3, 2);
    step();
    drive(1'b0, 0, 0);
    rst = 1'b1;
    step();
    check_reset_state("rst_mid");
    rst = 1'b0;
    ordy = 4'hF;
    step();
    step();

`ifdef DEMUX_BCAST_EN
    // Broadcast blocked by full ch2 until it drains.
    ordy = 4'b1011;
    drive(1'b1, 2, 3);
    step();
    bcast = 1'b1;
    drive(1'b1, 0, 1);
    step();
    check("bc_stall", int'(last_fire), 0);
    ordy = 4'hF;
    step();
    check("bc_fire", int'(last_fire), 1);
    bcast = 1'b0;
    drive(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) check($sformatf("bc_data%0d", i), int'(od[i]), 1);
    check("bc_valid", int'(ov), 15);
    step();
    step();
`endif

    // Random traffic honouring the hold-while-stalled rule.
    for (int k = 0; k < 60; k++) begin
      ordy = 4'($urandom_range(0, 15));
      if (!in_valid || last_fire)
        drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      step();
    end
    drive(1'b0, 0, 0);
    ordy = 4'hF;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
